vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receive-side counterpart of the VGA driver path: samples an incoming HS/VS/RGB stream in the pixel-clock domain and recovers pixel coordinates.
- Checks the recovered timing against the 1024x768@60 (65 MHz) XGA format and reports lock.
- Emits qualified pixels with x/y for a frame grabber or loopback checker, e.g. capturing our own driver's output on the board.

Parameters:
- H_ACTIVE 1024: visible pixels per line
- H_FP 24: horizontal front porch, pixels
- H_SYNC 136: HS pulse width, pixels
- H_BP 160: horizontal back porch, pixels
- V_ACTIVE 768: visible lines per frame
- V_FP 3: vertical front porch, lines
- V_SYNC 6: VS pulse width, lines
- V_BP 29: vertical back porch, lines
- SYNC_POL 0: asserted level of HS/VS (0 = active-low, XGA)

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst  in  1  synchronous reset, active-high
- HS  in  1  horizontal sync from source
- VS  in  1  vertical sync from source
- RGB  in  12  {R[3:0],G[3:0],B[3:0]}
- pix_valid  out  1  pixel in active area and locked
- pix_x  out  11  active-area column, 0..H_ACTIVE-1
- pix_y  out  10  active-area row, 0..V_ACTIVE-1
- pix_rgb  out  12  registered RGB for this pixel
- frame_start  out  1  one-cycle pulse at first active pixel (0,0) of a locked frame
- locked  out  1  timing matches parameters
- err_count  out  8  timing errors while locked, saturating

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst is synchronous and active-high.
  - On rst: every output is 0, FSM goes to HUNT, all counters are 0, and hcnt/vcnt are set to their saturation values.
- Input stage:
  - HS, VS and RGB are registered once (stage s1).
  - hs_a = (s1_HS == SYNC_POL); vs_a likewise.
  - hs_edge = hs_a & ~hs_a_d. vs_edge is defined likewise.
- Totals and offsets:
  - H_TOTAL = sum of the H parameters (1344).
  - V_TOTAL = sum of the V parameters (806).
  - HOFF = H_SYNC+H_BP (296).
  - VOFF = V_SYNC+V_BP (35).
- Horizontal counter hcnt (11 bit):
  - On hs_edge: 0.
  - Otherwise: +1, saturating at 2047.
- Vertical counter vcnt (10 bit):
  - vs_edge sets vs_pend.
  - On hs_edge with vs_pend (or vs_edge in the same cycle): vcnt=0 and vs_pend is cleared.
  - On any other hs_edge: vcnt+1, saturating at 1023.
- Line and frame checks:
  - line_ok: at hs_edge, pre-update hcnt == H_TOTAL-1.
  - frame_ok: at a vcnt reset, pre-update vcnt == V_TOTAL-1.
- Lock FSM:
  - HUNT: on a vcnt reset, go to CHECK.
  - CHECK: any hs_edge with !line_ok goes to HUNT. At the next vcnt reset, frame_ok goes to LOCKED, else HUNT.
  - LOCKED: any !line_ok or !frame_ok goes to HUNT and increments err_count (saturates at 255).
  - locked = (state == LOCKED).
  - The first line after reset always fails its check; this is harmless because the FSM is in HUNT.
- Output stage (registered from s1 data):
  - Active when hcnt in [HOFF, HOFF+H_ACTIVE) and vcnt in [VOFF, VOFF+V_ACTIVE).
  - pix_valid = active & locked.
  - pix_x = hcnt-HOFF; pix_y = vcnt-VOFF.
  - pix_rgb = s1_RGB.
  - When pix_valid=0: pix_x, pix_y and pix_rgb are 0.
- Latency: RGB sampled at edge n appears on pix_rgb after edge n+2. The pixel at edge n+1 of s1 is the first coordinate stage.
- frame_start = pix_valid & pix_x==0 & pix_y==0 (registered with the pixel).
- Simultaneous events:
  - Lock loss on a cycle where active is true: pix_valid drops in that same output cycle.
  - rst has priority over all events.
  - Reset mid-frame requires a full good frame before locked reasserts.

Decomposition:
- Package vga_pkg holds:
  - XGA timing constants: H/V active, porches, sync widths, totals.
  - SYNC_POL.
  - Lock-state enum {HUNT, CHECK, LOCKED}.
- VGA_Control also adopts vga_pkg.
- One sub-module, vga_sync_edge: input register, polarity normalisation and edge detect for one sync signal. It is instantiated twice, for HS and VS.

Test Plan:
- Drive two full frames from VGA_Control with RGB=12'hF00 -> locked rises at start of frame 2. frame_start pulses once per frame. 1024*768 pix_valid cycles per frame, all with pix_rgb=F00.
- Ramp RGB = hcnt[11:0] in frame 2 -> pix_x=0 carries RGB value 296. pix_x=1023 carries value 1319. pix_y runs 0..767.
- While locked, shorten one line to 1343 clocks -> locked falls at that hs_edge and err_count=1. Relock after one full good frame.
- While locked, emit a frame of 805 lines -> locked falls at the VS-triggered vcnt reset and err_count increments.
- Assert rst for 1 cycle mid-active-area -> next cycle all outputs are 0. Lock returns only after the next complete good frame.
- SYNC_POL=1 build fed with inverted syncs -> identical pix_x/pix_y/locked behaviour to the SYNC_POL=0 case.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared XGA (1024x768@60, 65 MHz) timing constants, lock-state encoding and
// saturating counter helpers for the VGA capture path.
package vga_pkg;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;
  localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;
  localparam logic XGA_SYNC_POL = 1'b0;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_e;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// One sync input: sample once, normalise polarity to "asserted = 1" and
// flag the first cycle of each asserted pulse.
module vga_sync_edge #(
  parameter logic POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic sync_edge
);

  logic s1_r;
  logic act_d_r;
  logic act_s;

  assign act_s     = (s1_r == POL);
  assign sync_edge = act_s & ~act_d_r;

  // Input register and delayed asserted level; reset parks the line deasserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r    <= ~POL;
      act_d_r <= 1'b0;
    end else begin
      s1_r    <= sync_in;
      act_d_r <= act_s;
    end
  end

endmodule

// File: rtl/vga_capture.sv
// Pixel-clock capture of an HS/VS/RGB stream: recovers x/y from the syncs,
// checks the line/frame totals against the timing parameters and qualifies pixels.
module vga_capture
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = XGA_H_ACTIVE,
  parameter int   H_FP     = XGA_H_FP,
  parameter int   H_SYNC   = XGA_H_SYNC,
  parameter int   H_BP     = XGA_H_BP,
  parameter int   V_ACTIVE = XGA_V_ACTIVE,
  parameter int   V_FP     = XGA_V_FP,
  parameter int   V_SYNC   = XGA_V_SYNC,
  parameter int   V_BP     = XGA_V_BP,
  parameter logic SYNC_POL = XGA_SYNC_POL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HS,
  input  logic        VS,
  input  logic [11:0] RGB,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HOFF    = H_SYNC + H_BP;
  localparam int VOFF    = V_SYNC + V_BP;

  localparam logic [10:0] H_LAST_L = 11'(H_TOTAL - 1);
  localparam logic [10:0] HOFF_L   = 11'(HOFF);
  localparam logic [10:0] HEND_L   = 11'(HOFF + H_ACTIVE);
  localparam logic [9:0]  V_LAST_L = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VOFF_L   = 10'(VOFF);
  localparam logic [9:0]  VEND_L   = 10'(VOFF + V_ACTIVE);

  logic        hs_edge_s;
  logic        vs_edge_s;
  logic [11:0] s1_rgb_r;
  logic [11:0] s2_rgb_r;
  logic [10:0] hcnt_r;
  logic [9:0]  vcnt_r;
  logic        vs_pend_r;
  lock_state_e state_r;
  lock_state_e state_next_s;
  logic        err_inc_s;
  logic        line_ok_s;
  logic        frame_ok_s;
  logic        vreset_s;
  logic        active_s;
  logic        valid_s;
  logic [10:0] x_s;
  logic [9:0]  y_s;
  logic [11:0] rgb_s;

  vga_sync_edge #(.POL(SYNC_POL)) u_hs (
    .clk       (clk),
    .rst       (rst),
    .sync_in   (HS),
    .sync_edge (hs_edge_s)
  );

  vga_sync_edge #(.POL(SYNC_POL)) u_vs (
    .clk       (clk),
    .rst       (rst),
    .sync_in   (VS),
    .sync_edge (vs_edge_s)
  );

  // A VS edge only restarts the frame at the next line start (or the same one).
  assign vreset_s   = hs_edge_s & (vs_pend_r | vs_edge_s);
  assign line_ok_s  = (hcnt_r == H_LAST_L);
  assign frame_ok_s = (vcnt_r == V_LAST_L);

  // Lock FSM next state and error-count request.
  always_comb begin
    state_next_s = state_r;
    err_inc_s    = 1'b0;
    case (state_r)
      ST_HUNT: begin
        if (vreset_s) begin
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_HUNT;
        end
      end
      ST_CHECK: begin
        if (hs_edge_s && !line_ok_s) begin
          state_next_s = ST_HUNT;
        end else if (vreset_s) begin
          state_next_s = frame_ok_s ? ST_LOCKED : ST_HUNT;
        end else begin
          state_next_s = ST_CHECK;
        end
      end
      ST_LOCKED: begin
        if (hs_edge_s && (!line_ok_s || (vreset_s && !frame_ok_s))) begin
          state_next_s = ST_HUNT;
          err_inc_s    = 1'b1;
        end else begin
          state_next_s = ST_LOCKED;
        end
      end
      default: begin
        state_next_s = ST_HUNT;
      end
    endcase
  end

  // Pixel pipeline, position counters, lock state and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rgb_r  <= 12'd0;
      s2_rgb_r  <= 12'd0;
      hcnt_r    <= 11'h7FF;
      vcnt_r    <= 10'h3FF;
      vs_pend_r <= 1'b0;
      state_r   <= ST_HUNT;
      locked    <= 1'b0;
      err_count <= 8'd0;
    end else begin
      s1_rgb_r <= RGB;
      s2_rgb_r <= s1_rgb_r;
      hcnt_r   <= hs_edge_s ? 11'd0 : sat_inc11(hcnt_r);
      if (vreset_s) begin
        vcnt_r <= 10'd0;
      end else if (hs_edge_s) begin
        vcnt_r <= sat_inc10(vcnt_r);
      end
      if (vreset_s) begin
        vs_pend_r <= 1'b0;
      end else if (vs_edge_s) begin
        vs_pend_r <= 1'b1;
      end
      state_r   <= state_next_s;
      locked    <= (state_next_s == ST_LOCKED);
      err_count <= err_inc_s ? sat_inc8(err_count) : err_count;
    end
  end

  // Active-area decode; coordinates and colour are forced to zero when not qualified.
  always_comb begin
    active_s = (hcnt_r >= HOFF_L) && (hcnt_r < HEND_L) &&
               (vcnt_r >= VOFF_L) && (vcnt_r < VEND_L);
    valid_s  = active_s && (state_r == ST_LOCKED);
    x_s      = 11'd0;
    y_s      = 10'd0;
    rgb_s    = 12'd0;
    if (valid_s) begin
      x_s   = hcnt_r - HOFF_L;
      y_s   = vcnt_r - VOFF_L;
      rgb_s = s2_rgb_r;
    end else begin
      x_s   = 11'd0;
      y_s   = 10'd0;
      rgb_s = 12'd0;
    end
  end

  // Registered pixel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      pix_x       <= 11'd0;
      pix_y       <= 10'd0;
      pix_rgb     <= 12'd0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= valid_s;
      pix_x       <= x_s;
      pix_y       <= y_s;
      pix_rgb     <= rgb_s;
      frame_start <= valid_s && (x_s == 11'd0) && (y_s == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a scaled-down timing: an event-level model of the
// sync stream predicts every output of an active-low and an active-high build.
module tb_vga_capture;

  localparam int H_ACT = 20, H_FP = 3, H_SYNC = 4, H_BP = 5;
  localparam int V_ACT = 6,  V_FP = 1, V_SYNC = 2, V_BP = 3;
  localparam int H_T = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_T = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HOFF = H_SYNC + H_BP;
  localparam int VOFF = V_SYNC + V_BP;

  logic clk = 1'b0;
  logic rst, hs_l, vs_l;
  logic [11:0] rgb;
  logic hs_n, vs_n;
  assign hs_n = ~hs_l;
  assign vs_n = ~vs_l;

  logic a_valid, a_fs, a_locked, b_valid, b_fs, b_locked;
  logic [10:0] a_x, b_x;
  logic [9:0] a_y, b_y;
  logic [11:0] a_rgb, b_rgb;
  logic [7:0] a_err, b_err;

  vga_capture #(.H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
                .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
                .SYNC_POL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .HS(hs_n), .VS(vs_n), .RGB(rgb),
    .pix_valid(a_valid), .pix_x(a_x), .pix_y(a_y), .pix_rgb(a_rgb),
    .frame_start(a_fs), .locked(a_locked), .err_count(a_err));

  vga_capture #(.H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
                .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
                .SYNC_POL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .HS(hs_l), .VS(vs_l), .RGB(rgb),
    .pix_valid(b_valid), .pix_x(b_x), .pix_y(b_y), .pix_rgb(b_rgb),
    .frame_start(b_fs), .locked(b_locked), .err_count(b_err));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit v; int x; int y; int c; bit fs; } pix_t;
  localparam int HUNT = 0, CHECK = 1, LOCK = 2;

  bit   armed = 1'b0;
  pix_t r1, r2, p;
  int   m_pos, m_line, m_state, m_err;
  bit   m_phs, m_pvs, m_vwait;
  bit   e_v, e_fs, e_locked;
  int   e_x, e_y, e_c, e_err;

  // Per input sample: line position/line number since the last HS/VS start,
  // lock status from measured line length and lines per frame.
  always @(posedge clk) begin
    if (rst) begin
      armed = 1'b1;
      e_v = 0; e_x = 0; e_y = 0; e_c = 0; e_fs = 0; e_locked = 0; e_err = 0;
      m_pos = -1; m_line = -1; m_state = HUNT; m_err = 0;
      m_phs = 0; m_pvs = 0; m_vwait = 0;
      r1 = '{default: 0};
      r2 = '{default: 0};
    end else begin
      bit hs_start, vs_start, full_line, full_frame, new_frame;
      e_locked = (m_state == LOCK);
      e_err    = m_err;
      e_v = r2.v; e_x = r2.x; e_y = r2.y; e_c = r2.c; e_fs = r2.fs;
      hs_start = hs_l && !m_phs;
      vs_start = vs_l && !m_pvs;
      if (vs_start) m_vwait = 1;
      if (hs_start) begin
        full_line  = (m_pos == H_T - 1);
        full_frame = (m_line == V_T - 1);
        new_frame  = m_vwait;
        if (m_state == HUNT) begin
          if (new_frame) m_state = CHECK;
        end else if (m_state == CHECK) begin
          if (!full_line) m_state = HUNT;
          else if (new_frame) m_state = full_frame ? LOCK : HUNT;
        end else begin
          if (!full_line || (new_frame && !full_frame)) begin
            m_state = HUNT;
            if (m_err < 255) m_err++;
          end
        end
        m_pos = 0;
        if (new_frame) begin
          m_line = 0;
          m_vwait = 0;
        end else if (m_line >= 0 && m_line < 1023) begin
          m_line++;
        end
      end else if (m_pos >= 0 && m_pos < 2047) begin
        m_pos++;
      end
      p.v = (m_pos >= HOFF) && (m_pos < HOFF + H_ACT) &&
            (m_line >= VOFF) && (m_line < VOFF + V_ACT) && (m_state == LOCK);
      p.x  = p.v ? m_pos - HOFF : 0;
      p.y  = p.v ? m_line - VOFF : 0;
      p.c  = p.v ? int'(rgb) : 0;
      p.fs = p.v && (p.x == 0) && (p.y == 0);
      r2 = r1;
      r1 = p;
      m_phs = hs_l;
      m_pvs = vs_l;
    end
  end

  // ---------------- compare process ----------------
  bit win = 1'b0;
  int valid_cnt, fs_cnt, bad_rgb, ramp_x0, ramp_xl, ymax;

  always @(negedge clk) begin
    if (armed) begin
      chk("a.valid", int'(a_valid), int'(e_v));
      chk("a.x", int'(a_x), e_x);
      chk("a.y", int'(a_y), e_y);
      chk("a.rgb", int'(a_rgb), e_c);
      chk("a.frame_start", int'(a_fs), int'(e_fs));
      chk("a.locked", int'(a_locked), int'(e_locked));
      chk("a.err_count", int'(a_err), e_err);
      chk("b.valid", int'(b_valid), int'(e_v));
      chk("b.x", int'(b_x), e_x);
      chk("b.y", int'(b_y), e_y);
      chk("b.rgb", int'(b_rgb), e_c);
      chk("b.frame_start", int'(b_fs), int'(e_fs));
      chk("b.locked", int'(b_locked), int'(e_locked));
      chk("b.err_count", int'(b_err), e_err);
    end
    if (win && a_valid) begin
      valid_cnt++;
      if (a_rgb != 12'hF00) bad_rgb++;
      if (a_x == 11'd0 && a_y == 10'd0) ramp_x0 = int'(a_rgb);
      if (a_x == 11'(H_ACT - 1) && a_y == 10'd0) ramp_xl = int'(a_rgb);
      if (int'(a_y) > ymax) ymax = int'(a_y);
    end
    if (win && a_fs) fs_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic h, input logic v, input logic [11:0] c);
    @(posedge clk);
    #1;
    rst = r; hs_l = h; vs_l = v; rgb = c;
  endtask

  task automatic open_win();
    valid_cnt = 0; fs_cnt = 0; bad_rgb = 0; ramp_x0 = -1; ramp_xl = -1; ymax = -1;
    win = 1'b1;
  endtask

  // mode 0: solid F00, 1: ramp of line position, 2: random colour
  task automatic send_frame(input int nlines, input int mode, input int bad_line,
                            input int bad_len, input int rst_line, input int rst_pix);
    int len;
    bit r, post_rst;
    logic [11:0] c;
    post_rst = 0;
    for (int ln = 0; ln < nlines; ln++) begin
      len = (ln == bad_line) ? bad_len : H_T;
      for (int px = 0; px < len; px++) begin
        r = (ln == rst_line) && (px == rst_pix);
        case (mode)
          0:       c = 12'hF00;
          1:       c = 12'(px);
          default: c = 12'($urandom);
        endcase
        drive(r, px < H_SYNC, ln < V_SYNC, c);
        if (post_rst) begin
          chk("reset.valid", int'(a_valid), 0);
          chk("reset.locked", int'(a_locked), 0);
          chk("reset.err_count", int'(a_err), 0);
          chk("reset.rgb", int'(a_rgb), 0);
          post_rst = 0;
        end
        if (r) post_rst = 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; hs_l = 1'b0; vs_l = 1'b0; rgb = 12'd0;
    drive(1'b1, 1'b0, 1'b0, 12'd0);
    drive(1'b1, 1'b0, 1'b0, 12'd0);
    drive(1'b0, 1'b0, 1'b0, 12'd0);
    chk("por.locked", int'(a_locked), 0);
    chk("por.err_count", int'(a_err), 0);
    chk("por.valid", int'(a_valid), 0);

    send_frame(V_T, 0, -1, 0, -1, -1);
    chk("f1.locked", int'(a_locked), 0);
    open_win();
    send_frame(V_T, 0, -1, 0, -1, -1);
    win = 1'b0;
    chk("f2.locked", int'(a_locked), 1);
    chk("f2.valid_count", valid_cnt, H_ACT * V_ACT);
    chk("f2.frame_starts", fs_cnt, 1);
    chk("f2.non_f00", bad_rgb, 0);

    open_win();
    send_frame(V_T, 1, -1, 0, -1, -1);
    win = 1'b0;
    chk("ramp.x0_rgb", ramp_x0, 9);
    chk("ramp.xlast_rgb", ramp_xl, 28);
    chk("ramp.ymax", ymax, 5);
    chk("ramp.valid_count", valid_cnt, 120);

    send_frame(V_T, 2, 7, H_T - 1, -1, -1);
    chk("short.err_count", int'(a_err), 1);
    chk("short.locked", int'(a_locked), 0);
    send_frame(V_T, 2, -1, 0, -1, -1);
    chk("relock1.locked", int'(a_locked), 0);
    send_frame(V_T, 2, -1, 0, -1, -1);
    chk("relock2.locked", int'(a_locked), 1);

    send_frame(V_T - 1, 2, -1, 0, -1, -1);
    send_frame(V_T, 2, -1, 0, -1, -1);
    chk("shortframe.err_count", int'(a_err), 2);
    chk("shortframe.locked", int'(a_locked), 0);
    send_frame(V_T, 2, -1, 0, -1, -1);
    send_frame(V_T, 2, -1, 0, -1, -1);
    chk("shortframe.relock", int'(a_locked), 1);

    send_frame(V_T, 2, -1, 0, 7, 15);
    chk("midrst.locked", int'(a_locked), 0);
    send_frame(V_T, 2, -1, 0, -1, -1);
    chk("midrst.frame1", int'(a_locked), 0);
    send_frame(V_T, 2, -1, 0, -1, -1);
    chk("midrst.frame2", int'(a_locked), 1);

    for (int f = 0; f < 6; f++) begin
      send_frame(($urandom_range(0, 3) == 0) ? V_T - 1 : V_T, 2,
                 int'($urandom_range(0, 15)), H_T - 1 + int'($urandom_range(0, 2)), -1, -1);
    end
    for (int f = 0; f < 3; f++) send_frame(V_T, 2, -1, 0, -1, -1);
    chk("final.locked", int'(a_locked), 1);

    drive(1'b0, 1'b0, 1'b0, 12'd0);
    drive(1'b0, 1'b0, 1'b0, 12'd0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
